// File: rtl/sram_stream_reader.sv
// Streams a (base, count) run of rows out of the 1-cycle registered-read row SRAM onto a valid/ready port.
// Define SRAM_STREAM_READER_PERF_EN to add the stall_cycles backpressure counter port.
module sram_stream_reader #(
  parameter int WIDTH        = 512,
  parameter int LOG_NUM_ROWS = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [LOG_NUM_ROWS-1:0] req_base,
  input  logic [LOG_NUM_ROWS:0]   req_count,
  output logic [LOG_NUM_ROWS-1:0] readAddr,
  input  logic [WIDTH-1:0]        readData,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              stateDbg
`ifdef SRAM_STREAM_READER_PERF_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and the payload is held stable while valid && !ready.

  localparam int NUM_ROWS = 2 ** LOG_NUM_ROWS;
  localparam logic [LOG_NUM_ROWS-1:0] LAST_ROW = LOG_NUM_ROWS'(NUM_ROWS - 1);
  localparam logic [LOG_NUM_ROWS:0]   ONE_ROW  = (LOG_NUM_ROWS + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stateT;

  stateT state;
  stateT stateNext;

  logic [LOG_NUM_ROWS-1:0] addr;
  logic [LOG_NUM_ROWS:0]   remaining;
  logic                    inFlight;
  logic                    inFlightLast;
  logic                    doneReg;

  logic [WIDTH-1:0] fifoData [2];
  logic             fifoLast [2];
  logic             wrPtr;
  logic             rdPtr;
  logic [1:0]       fifoCount;

  logic accept;
  logic issue;
  logic doneNext;
  logic pop;
  logic push;
  logic headLast;
  logic roomForIssue;

  assign out_valid = (fifoCount != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = inFlight;
  assign headLast  = fifoLast[rdPtr];

  // Rows already buffered or still in the SRAM pipe must leave room for one more.
  assign roomForIssue = ({1'b0, fifoCount} + {2'b00, inFlight}) < (3'd2 + {2'b00, pop});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    issue     = 1'b0;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_count == '0) doneNext = 1'b1;
          else                 stateNext = RUN;
        end
      end
      RUN: begin
        if ((remaining != '0) && roomForIssue) begin
          issue = 1'b1;
          if (remaining == ONE_ROW) stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && headLast) begin
          doneNext  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr         <= '0;
      remaining    <= '0;
      inFlight     <= 1'b0;
      inFlightLast <= 1'b0;
      doneReg      <= 1'b0;
    end else begin
      doneReg      <= doneNext;
      inFlight     <= issue;
      inFlightLast <= issue && (remaining == ONE_ROW);
      if (accept) begin
        addr      <= req_base;
        remaining <= req_count;
      end else if (issue) begin
        addr      <= (addr == LAST_ROW) ? '0 : addr + 1'b1;
        remaining <= remaining - ONE_ROW;
      end
    end
  end

  // Two-entry output buffer; pushes come straight from the SRAM read pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        fifoData[i] <= '0;
        fifoLast[i] <= 1'b0;
      end
      wrPtr     <= 1'b0;
      rdPtr     <= 1'b0;
      fifoCount <= 2'd0;
    end else begin
      if (push) begin
        fifoData[wrPtr] <= readData;
        fifoLast[wrPtr] <= inFlightLast;
        wrPtr           <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 2'd1;
        2'b01:   fifoCount <= fifoCount - 2'd1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

`ifdef SRAM_STREAM_READER_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (accept) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  // req_ready is gated by reset directly so it reads 0 for the whole reset window.
  assign req_ready = (state == IDLE) && !reset;
  assign readAddr  = addr;
  assign out_data  = fifoData[rdPtr];
  assign out_last  = headLast;
  assign busy      = (state != IDLE);
  assign done      = doneReg;
  assign stateDbg  = state;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Randomized bench for sram_stream_reader: behavioural SRAM, expected-beat queue built from (base, count).
module tb_sram_stream_reader;

  localparam int WIDTH    = 512;
  localparam int LOG      = 9;
  localparam int NUM_ROWS = 512;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [LOG-1:0]   req_base;
  logic [LOG:0]     req_count;
  logic [LOG-1:0]   readAddr;
  logic [WIDTH-1:0] readData;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  logic [1:0]       stateDbg;
`ifdef SRAM_STREAM_READER_PERF_EN
  logic [31:0]      stall_cycles;
`endif

  logic [WIDTH-1:0] mem [NUM_ROWS];
  logic [WIDTH:0]   exp_q[$];
  int checks;
  int failures;
  int readyMode;
  int rdyPhase;
  int stallCount;
  int doneSeen;

  sram_stream_reader #(.WIDTH(WIDTH), .LOG_NUM_ROWS(LOG)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_count(req_count),
    .readAddr(readAddr), .readData(readData),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .stateDbg(stateDbg)
`ifdef SRAM_STREAM_READER_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // behavioural SRAM with a 1-cycle registered read
  always @(posedge clk) readData <= mem[readAddr];

  task automatic check(input string tag, input logic [WIDTH:0] actual, input logic [WIDTH:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // downstream ready driver
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = ((rdyPhase % 4) == 0) || ((rdyPhase % 4) == 3);
        rdyPhase++;
      end
    endcase
  end

  // scoreboard: every valid beat must equal the head of the expected queue
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        check("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check("beat", {out_last, out_data}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
        if (!out_ready) stallCount++;
      end
      if (done) doneSeen++;
    end
  end

  // driver tasks
  task automatic start_req(input int base, input int count);
    req_base  = LOG'(base);
    req_count = (LOG + 1)'(count);
    req_valid = 1'b1;
    @(negedge clk);
    check("req_ready_at_accept", req_ready, 1'b1);
    for (int i = 0; i < count; i++)
      exp_q.push_back({(i == count - 1), mem[(base + i) % NUM_ROWS]});
    stallCount = 0;
    doneSeen   = 0;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (doneSeen == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", doneSeen != 0, 1'b1);
    check("queue_drained", exp_q.size(), 0);
`ifdef SRAM_STREAM_READER_PERF_EN
    check("stall_cycles", stall_cycles, stallCount);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bubbles;
    int base;
    int count;
    int n;
    checks = 0; failures = 0; readyMode = 0; rdyPhase = 0;
    stallCount = 0; doneSeen = 0;
    req_valid = 1'b0; req_base = '0; req_count = '0; out_ready = 1'b1;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int w = 0; w < WIDTH / 32; w++) mem[r][w*32 +: 32] = $urandom;
    reset = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out_data", out_data, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;

    // directed timing: base 5, count 4, ready held high
    readyMode = 0;
    start_req(5, 4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 4) check($sformatf("readAddr_c%0d", c), readAddr, 4 + c);
      check($sformatf("out_valid_c%0d", c), out_valid, (c >= 3 && c <= 6));
      check($sformatf("done_c%0d", c), done, (c == 7));
    end
    check("t1_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // address wrap
    start_req(510, 4);
    wait_done(40);

    // 1,0,0,1 backpressure pattern
    readyMode = 2; rdyPhase = 0;
    start_req($urandom_range(0, NUM_ROWS - 1), 8);
    wait_done(100);

    // zero-length request
    readyMode = 0;
    start_req(77, 0);
    @(negedge clk);
    check("zero_done", done, 1'b1);
    check("zero_out_valid", out_valid, 1'b0);
    check("zero_busy", busy, 1'b0);
    @(posedge clk);
    #1;

    // full sweep without bubbles
    start_req(0, NUM_ROWS);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("sweep_started", out_valid, 1'b1);
    bubbles = 0;
    for (int i = 0; i < NUM_ROWS - 1; i++) begin
      @(negedge clk);
      if (!out_valid) bubbles++;
    end
    check("sweep_bubbles", bubbles, 0);
    wait_done(20);

    // randomized requests
    for (int k = 0; k < 25; k++) begin
      readyMode = $urandom_range(0, 2);
      rdyPhase  = 0;
      base  = $urandom_range(0, NUM_ROWS - 1);
      count = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
      start_req(base, count);
      wait_done(count * 20 + 50);
    end

    // reset during beat 3 of a 6-row request
    readyMode = 0;
    start_req(100, 6);
    repeat (5) @(negedge clk);
    check("mid_beat3_valid", out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_req_ready", req_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_last", out_last, 1'b0);
    check("mid_rst_data", out_data, '0);
    check("mid_rst_addr", readAddr, '0);
    exp_q.delete();
    doneSeen = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_no_done", doneSeen, 0);
    check("mid_no_beats", exp_q.size(), 0);
    @(posedge clk);
    #1;
    start_req(20, 2);
    wait_done(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- Read-side streaming front end for the banked row SRAM.
- Accepts a (base row, row count) request, issues sequential row reads against the SRAM's 1-cycle registered read port, and delivers the rows in order on a valid/ready stream with full backpressure.
- Sits directly upstream of the SRAM read port. Downstream, it feeds the compute/unpack stage.

Parameters:
- WIDTH, 512, row width in bits; matches the SRAM WIDTH.
- LOG_NUM_ROWS, 9, SRAM address width; NUM_ROWS = 2**LOG_NUM_ROWS (localparam).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  reader idle; can accept a request.
- req_base  in  LOG_NUM_ROWS  first row to read.
- req_count  in  LOG_NUM_ROWS+1  number of rows, 0..NUM_ROWS.
- readAddr  out  LOG_NUM_ROWS  to SRAM readAddr.
- readData  in  WIDTH  from SRAM readData.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  WIDTH  row data.
- out_last  out  1  final beat of the request.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on request completion.

Behaviour:
- Reset: asserting reset immediately returns state to IDLE and clears all counters, the in-flight flag and the FIFO. All outputs are 0 during reset, including req_ready. Reset mid-request drops the request silently with no done pulse.
- SRAM timing contract:
  - readAddr presented in cycle t is sampled at the end of t.
  - readData is valid during t+1 and is captured into the FIFO at the end of t+1.
  - in_flight is a registered flag meaning "readData carries a requested row this cycle".
- Output buffer: 2-entry FIFO holding {data, last}. out_valid = FIFO non-empty. A pop occurs when out_valid && out_ready.
- Issue rule: issue a read in cycle t only if all of the following hold:
  - state == RUN;
  - remaining > 0;
  - fifo_count + in_flight - pop < 2.
  This guarantees no overflow and sustains 1 beat/cycle when out_ready is held at 1.
- readAddr = addr register at all times; it is meaningful only on issue cycles.
- Address arithmetic: addr increments modulo NUM_ROWS on each issue (NUM_ROWS-1 wraps to 0). remaining decrements by 1 on each issue. last_tag = (remaining == 1) at issue; it travels with in_flight.
- req_count > NUM_ROWS is not representable. req_count == NUM_ROWS reads every row exactly once, starting at req_base.
- State machine:
  - IDLE: req_ready = 1. On req_valid, load addr = req_base and remaining = req_count. If req_count == 0, go to IDLE and pulse done the next cycle. Otherwise go to RUN.
  - RUN: issue per the issue rule. On the issue with remaining == 1, go to DRAIN.
  - DRAIN: no issues. When the beat with last = 1 is popped, pulse done in the following cycle and go to IDLE.
- Latency: request accepted in cycle 0 → first read issued in cycle 1 → earliest out_valid in cycle 3.
- Back-to-back requests: a new request is accepted in the cycle done is high. Beats of consecutive requests never interleave.
- Backpressure: out_data/out_last are held stable while out_valid && !out_ready. No beat is dropped or duplicated.
- Data returned is the SRAM contents at the sampling edge. Write/read ordering to the same row is the writer's responsibility.

Optional Feature:
- SRAM_STREAM_READER_PERF_EN defined:
  - Adds output port stall_cycles (32 bits).
  - Counts cycles with out_valid && !out_ready.
  - Saturates at 2**32-1.
  - Cleared by reset and on request acceptance.
- Not defined: port and counter are absent; the behaviour is otherwise identical.

Test Plan:
- Reset, then base=5, count=4, out_ready=1 → readAddr 5,6,7,8 in cycles 1-4; beats rows 5..8 in cycles 3-6; out_last only on row 8; done in cycle 7.
- Base=510, count=4 (LOG_NUM_ROWS=9) → rows 510, 511, 0, 1 in order; out_last on row 1.
- Count=8 with out_ready toggling 1,0,0,1,… → all 8 rows delivered exactly once, in order, data stable while stalled; in_flight+FIFO never exceeds 2; with PERF_EN, stall_cycles equals the number of stalled valid cycles.
- Count=0 → req_ready high in cycle 0, no readAddr issue and no out_valid, done pulse in cycle 1.
- Count=512, base=0, out_ready=1 → 512 consecutive beats, one per cycle, no bubbles after the first.
- Assert reset during beat 3 of a count=6 request → outputs 0 immediately; no done; a subsequent base=20, count=2 request returns rows 20 and 21 only.
